// File: rtl/au_incdec_serial.sv
// au_incdec_serial
//   Word-serial incrementer/decrementer. An operand arrives as a little-endian
//   stream of WIDTH-bit words. A single +/-ci is applied to the whole operand.
//   Carry or borrow ripples from word to word through carry_q. Results leave
//   through one registered output stage, so each beat has a latency of one cycle.
//
//   Ports:
//     clk, rst           clock; asynchronous active-high reset
//     in_valid/in_ready  input handshake
//     in_data            operand word, least-significant word first
//     in_last            marks the most-significant word of the operand
//     in_ci, in_inc_dec  carry-in and op (0 inc, 1 dec); used on the first beat only
//     out_valid/out_ready output handshake
//     out_data, out_last result word and end-of-packet marker
//     out_co             carry/borrow out of this word
//     ovf_cnt            (AU_INCDEC_SERIAL_OVF_CNT_EN only) saturating count of
//                        whole-operand overflows/underflows
//
//   Optional feature macro: AU_INCDEC_SERIAL_OVF_CNT_EN
module au_incdec_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_ci,
    input  logic             in_inc_dec,
`ifdef AU_INCDEC_SERIAL_OVF_CNT_EN
    output logic [15:0]      ovf_cnt,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_co
);

    typedef enum logic {S_FIRST = 1'b0, S_CHAIN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic             carry_q, op_q;
    logic             out_valid_q, out_last_q, out_co_q;
    logic [WIDTH-1:0] out_data_q;

    logic             accept;
    logic             c_sel, op_sel;
    logic [WIDTH:0]   sum;
    logic             co;

    // The output register can take a new beat when it is empty or being popped.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FIRST;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (accept) state_d = in_last ? S_FIRST : S_CHAIN;
    end

    // FSM: outputs. On the first word, carry and op come from the ports.
    // After that, they come from the registers.
    always_comb begin
        c_sel  = (state_q == S_FIRST) ? in_ci      : carry_q;
        op_sel = (state_q == S_FIRST) ? in_inc_dec : op_q;
    end

    // The extra top bit is the carry on increment and the borrow on decrement.
    always_comb begin
        if (op_sel) sum = {1'b0, in_data} - {{WIDTH{1'b0}}, c_sel};
        else        sum = {1'b0, in_data} + {{WIDTH{1'b0}}, c_sel};
        co = sum[WIDTH];
    end

    // Chain state. It updates only on accept, so it stays frozen during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
            op_q    <= 1'b0;
        end else if (accept) begin
            carry_q <= co;
            if (state_q == S_FIRST) op_q <= in_inc_dec;
        end
    end

    // Output stage. When a pop and an accept happen together, the register
    // reloads and out_valid stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_co_q    <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sum[WIDTH-1:0];
            out_last_q  <= in_last;
            out_co_q    <= co;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_co    = out_co_q;

`ifdef AU_INCDEC_SERIAL_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    // Count carry-out of the final word only; it saturates rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                               ovf_cnt_q <= '0;
        else if (accept && in_last && co && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_au_incdec_serial.sv
// Directed testbench for au_incdec_serial (WIDTH=8).
// Inputs change 1ns after the rising edge and outputs are sampled at that point.
module tb_au_incdec_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         in_ci = 1'b0;
    logic         in_inc_dec = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_co;
`ifdef AU_INCDEC_SERIAL_OVF_CNT_EN
    logic [15:0]  ovf_cnt;
`endif

    int total = 0;
    int bad   = 0;

    au_incdec_serial #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ci      (in_ci),
        .in_inc_dec (in_inc_dec),
`ifdef AU_INCDEC_SERIAL_OVF_CNT_EN
        .ovf_cnt    (ovf_cnt),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_co     (out_co)
    );

    always #5 clk = ~clk;

    // Protocol check: the inputs must stay stable while a beat is stalled.
    logic         pend = 1'b0;
    logic [W-1:0] p_data;
    logic         p_last, p_ci, p_op;
    always @(posedge clk) begin
        if (pend && in_valid && !rst &&
            ({in_data, in_last, in_ci, in_inc_dec} !== {p_data, p_last, p_ci, p_op})) begin
            $display("FAIL in_stable: got %h/%b%b%b required %h/%b%b%b",
                     in_data, in_last, in_ci, in_inc_dec, p_data, p_last, p_ci, p_op);
            bad++;
        end
        pend   = in_valid && !in_ready;
        p_data = in_data;
        p_last = in_last;
        p_ci   = in_ci;
        p_op   = in_inc_dec;
    end

    // Drive one beat, then wait for the edge that accepts it.
    task automatic push(input logic [W-1:0] d, input logic l, input logic ci, input logic op);
        in_valid   = 1'b1;
        in_data    = d;
        in_last    = l;
        in_ci      = ci;
        in_inc_dec = op;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, out_data, out_last, out_co, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset: got v%b d%h l%b co%b rdy%b required v0 d00 l0 co0 rdy1",
                     out_valid, out_data, out_last, out_co, in_ready);
            bad++;
        end
`ifdef AU_INCDEC_SERIAL_OVF_CNT_EN
        total++;
        if (ovf_cnt !== 16'd0) begin
            $display("FAIL reset_ovf: got %0d required 0", ovf_cnt);
            bad++;
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_inc_chain();
        logic [W-1:0] din [3] = '{8'hFF, 8'hFF, 8'h12};
        logic [W-1:0] exp [3] = '{8'h00, 8'h00, 8'h13};
        logic         eco [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            // ci/op on the chained beats are deliberately wrong; they must be ignored
            push(din[i], i == 2, (i == 0) ? 1'b1 : 1'b0, (i == 0) ? 1'b0 : 1'b1);
            total++;
            if ({out_valid, out_data, out_co, out_last} !== {1'b1, exp[i], eco[i], i == 2}) begin
                $display("FAIL inc_chain[%0d]: got v%b %h co%b l%b required v1 %h co%b l%b",
                         i, out_valid, out_data, out_co, out_last, exp[i], eco[i], i == 2);
                bad++;
            end
        end
        idle();
        total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL inc_drain: out_valid got %b required 0", out_valid);
            bad++;
        end
    endtask

    task automatic test_dec_borrow();
        for (int i = 0; i < 3; i++) begin
            push(8'h00, i == 2, 1'b1, 1'b1);
            total++;
            if ({out_data, out_co, out_last} !== {8'hFF, 1'b1, i == 2}) begin
                $display("FAIL dec_borrow[%0d]: got %h co%b l%b required ff co1 l%b",
                         i, out_data, out_co, out_last, i == 2);
                bad++;
            end
        end
        idle();
`ifdef AU_INCDEC_SERIAL_OVF_CNT_EN
        total++;
        if (ovf_cnt !== 16'd1) begin
            $display("FAIL dec_ovf: got %0d required 1", ovf_cnt);
            bad++;
        end
`endif
    endtask

    task automatic test_passthru();
        logic [W-1:0] din [2] = '{8'h5A, 8'hA5};
        for (int op = 0; op < 2; op++) begin
            for (int i = 0; i < 2; i++) begin
                // beat 2 presents ci=1, dec; the packet must ignore both
                push(din[i], i == 1, (i == 1) ? 1'b1 : 1'b0, (i == 1) ? 1'b1 : op[0]);
                total++;
                if ({out_data, out_co, out_last} !== {din[i], 1'b0, i == 1}) begin
                    $display("FAIL passthru[op%0d,%0d]: got %h co%b l%b required %h co0 l%b",
                             op, i, out_data, out_co, out_last, din[i], i == 1);
                    bad++;
                end
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        push(8'hFF, 1'b1, 1'b1, 1'b0);
        total++;
        if ({out_valid, out_data, out_co, out_last} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
            $display("FAIL b2b_inc: got v%b %h co%b l%b required v1 00 co1 l1",
                     out_valid, out_data, out_co, out_last);
            bad++;
        end
        push(8'h01, 1'b1, 1'b1, 1'b1);
        total++;
        if ({out_valid, out_data, out_co, out_last} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
            $display("FAIL b2b_dec: got v%b %h co%b l%b required v1 00 co0 l1",
                     out_valid, out_data, out_co, out_last);
            bad++;
        end
        idle();
`ifdef AU_INCDEC_SERIAL_OVF_CNT_EN
        total++;
        if (ovf_cnt !== 16'd2) begin
            $display("FAIL b2b_ovf: got %0d required 2", ovf_cnt);
            bad++;
        end
`endif
    endtask

    task automatic test_backpressure();
        push(8'hFF, 1'b0, 1'b1, 1'b0);
        total++;
        if ({out_data, out_co} !== {8'h00, 1'b1}) begin
            $display("FAIL bp_beat0: got %h co%b required 00 co1", out_data, out_co);
            bad++;
        end
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'hFF;
        in_last    = 1'b0;
        in_ci      = 1'b0;
        in_inc_dec = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({in_ready, out_valid, out_data, out_co, out_last} !== {1'b0, 1'b1, 8'h00, 1'b1, 1'b0}) begin
                $display("FAIL bp_stall[%0d]: got rdy%b v%b %h co%b l%b required rdy0 v1 00 co1 l0",
                         i, in_ready, out_valid, out_data, out_co, out_last);
                bad++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push(8'hFF, 1'b0, 1'b0, 1'b0);
        total++;
        if ({out_data, out_co, out_last} !== {8'h00, 1'b1, 1'b0}) begin
            $display("FAIL bp_beat1: got %h co%b l%b required 00 co1 l0", out_data, out_co, out_last);
            bad++;
        end
        push(8'h12, 1'b1, 1'b0, 1'b0);
        total++;
        if ({out_data, out_co, out_last} !== {8'h13, 1'b0, 1'b1}) begin
            $display("FAIL bp_beat2: got %h co%b l%b required 13 co0 l1", out_data, out_co, out_last);
            bad++;
        end
        idle();
    endtask

    task automatic test_reset_mid();
        push(8'hFF, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_data, out_last, out_co} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL rst_mid_clear: got v%b %h l%b co%b required v0 00 l0 co0",
                     out_valid, out_data, out_last, out_co);
            bad++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        // ci=0 single word: a leftover chain carry would turn FF into 00
        push(8'hFF, 1'b1, 1'b0, 1'b0);
        total++;
        if ({out_data, out_co, out_last} !== {8'hFF, 1'b0, 1'b1}) begin
            $display("FAIL rst_mid_ci0: got %h co%b l%b required ff co0 l1", out_data, out_co, out_last);
            bad++;
        end
        push(8'hFF, 1'b1, 1'b1, 1'b0);
        total++;
        if ({out_data, out_co, out_last} !== {8'h00, 1'b1, 1'b1}) begin
            $display("FAIL rst_mid_ci1: got %h co%b l%b required 00 co1 l1", out_data, out_co, out_last);
            bad++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_inc_chain();
        test_dec_borrow();
        test_passthru();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
